// File: rtl/tt_checker_pkg.sv
// rtl/tt_checker_pkg.sv - shared state encoding and sizing constants for tt_checker
package tt_checker_pkg;

    localparam int         NUM_VECTORS = 16;
    localparam logic [3:0] LAST_VEC    = 4'd15;
    localparam int         VEC_W       = 4;
    localparam int         CNT_W       = 5;
    localparam int         SETTLE_W    = 8;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SETTLE = 2'd1,
        ST_SAMPLE = 2'd2,
        ST_FINISH = 2'd3
    } tt_state_t;

endpackage

// File: rtl/tt_settle_timer.sv
// rtl/tt_settle_timer.sv - loadable down-counter that flags when a vector has settled
module tt_settle_timer
    import tt_checker_pkg::*;
(
    input  logic                clk,
    input  logic                rst_n,
    input  logic                load,
    input  logic [SETTLE_W-1:0] load_val,
    output logic                expired
);

    logic [SETTLE_W-1:0] r_cnt;

    // Count down from the loaded value and park at zero until reloaded.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_cnt <= '0;
        end else if (load) begin
            r_cnt <= load_val;
        end else if (r_cnt != '0) begin
            r_cnt <= r_cnt - 1'b1;
        end
    end

    assign expired = (r_cnt == '0);

endmodule

// File: rtl/tt_checker.sv
// rtl/tt_checker.sv - exhaustive 4-input truth-table sweeper; TT_CHECK_HALT_ON_MISMATCH_EN stops at first mismatch
module tt_checker
    import tt_checker_pkg::*;
#(
    parameter int SETTLE_CYCLES = 4
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start,
    input  logic [15:0] exp_table,
    input  logic        dut_out,
    output logic [3:0]  vec,
    output logic        busy,
    output logic        done,
    output logic        pass,
    output logic [4:0]  mismatch_cnt,
    output logic [15:0] captured,
    output logic [3:0]  first_fail_idx,
    output logic        first_fail_valid
);

    // The timer expires on the cycle it reads zero, so SETTLE lasts SETTLE_CYCLES cycles.
    localparam logic [SETTLE_W-1:0] SETTLE_RELOAD = SETTLE_W'(SETTLE_CYCLES - 1);

    tt_state_t r_state;
    tt_state_t w_state_next;

    logic [NUM_VECTORS-1:0] r_exp;
    logic [VEC_W-1:0]       r_vec;
    logic [CNT_W-1:0]       r_cnt;
    logic [NUM_VECTORS-1:0] r_cap;
    logic [VEC_W-1:0]       r_ffi;
    logic                   r_ffv;
    logic                   r_pass;

    logic             w_expired;
    logic             w_load;
    logic             w_accept;
    logic             w_sample;
    logic             w_advance;
    logic             w_miss;
    logic             w_halt;
    logic [CNT_W-1:0] w_cnt_next;

    tt_settle_timer u_settle (
        .clk      (clk),
        .rst_n    (rst_n),
        .load     (w_load),
        .load_val (SETTLE_RELOAD),
        .expired  (w_expired)
    );

    assign w_miss     = dut_out ^ r_exp[r_vec];
    assign w_cnt_next = r_cnt + CNT_W'(w_miss);

`ifdef TT_CHECK_HALT_ON_MISMATCH_EN
    assign w_halt = w_miss;
`else
    assign w_halt = 1'b0;
`endif

    // State register.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Next-state and datapath strobes; start is only honoured in IDLE.
    always_comb begin
        w_state_next = r_state;
        w_accept     = 1'b0;
        w_sample     = 1'b0;
        w_advance    = 1'b0;
        w_load       = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (start) begin
                    w_accept     = 1'b1;
                    w_load       = 1'b1;
                    w_state_next = ST_SETTLE;
                end
            end
            ST_SETTLE: begin
                if (w_expired) begin
                    w_state_next = ST_SAMPLE;
                end
            end
            ST_SAMPLE: begin
                w_sample = 1'b1;
                if (w_halt || (r_vec == LAST_VEC)) begin
                    w_state_next = ST_FINISH;
                end else begin
                    w_advance    = 1'b1;
                    w_load       = 1'b1;
                    w_state_next = ST_SETTLE;
                end
            end
            ST_FINISH: begin
                w_state_next = ST_IDLE;
            end
            default: begin
                w_state_next = ST_IDLE;
            end
        endcase
    end

    // Result registers; pass is resolved on entry to FINISH so it is valid alongside done.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_exp  <= '0;
            r_vec  <= '0;
            r_cnt  <= '0;
            r_cap  <= '0;
            r_ffi  <= '0;
            r_ffv  <= 1'b0;
            r_pass <= 1'b0;
        end else if (w_accept) begin
            r_exp  <= exp_table;
            r_vec  <= '0;
            r_cnt  <= '0;
            r_cap  <= '0;
            r_ffi  <= '0;
            r_ffv  <= 1'b0;
            r_pass <= 1'b0;
        end else if (w_sample) begin
            r_cap[r_vec] <= dut_out;
            if (w_miss) begin
                r_cnt <= w_cnt_next;
                if (!r_ffv) begin
                    r_ffv <= 1'b1;
                    r_ffi <= r_vec;
                end
            end
            if (w_advance) begin
                r_vec <= r_vec + 1'b1;
            end
            if (w_state_next == ST_FINISH) begin
                r_pass <= (w_cnt_next == '0);
            end
        end
    end

    assign vec              = r_vec;
    assign busy             = (r_state != ST_IDLE);
    assign done             = (r_state == ST_FINISH);
    assign pass             = r_pass;
    assign mismatch_cnt     = r_cnt;
    assign captured         = r_cap;
    assign first_fail_idx   = r_ffi;
    assign first_fail_valid = r_ffv;

endmodule

// File: tb/tb_tt_checker.sv
// tb/tb_tt_checker.sv - self-checking bench for tt_checker (SETTLE_CYCLES 4 and 1 instances)
module tb_tt_checker;

`ifdef TT_CHECK_HALT_ON_MISMATCH_EN
    localparam bit HALT = 1'b1;
`else
    localparam bit HALT = 1'b0;
`endif

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst_n;
    logic        start     [2];
    logic [15:0] exp_tbl   [2];
    logic        dut_out   [2];
    logic [3:0]  vec       [2];
    logic        busy      [2];
    logic        done      [2];
    logic        pass      [2];
    logic [4:0]  mcnt      [2];
    logic [15:0] cap       [2];
    logic [3:0]  ffi       [2];
    logic        ffv       [2];
    logic [15:0] fn_tbl    [2];

    int checks = 0;
    int errors = 0;

    for (genvar g = 0; g < 2; g++) begin : g_dut
        tt_checker #(.SETTLE_CYCLES(g == 0 ? 4 : 1)) u_dut (
            .clk              (clk),
            .rst_n            (rst_n),
            .start            (start[g]),
            .exp_table        (exp_tbl[g]),
            .dut_out          (dut_out[g]),
            .vec              (vec[g]),
            .busy             (busy[g]),
            .done             (done[g]),
            .pass             (pass[g]),
            .mismatch_cnt     (mcnt[g]),
            .captured         (cap[g]),
            .first_fail_idx   (ffi[g]),
            .first_fail_valid (ffv[g])
        );
        assign dut_out[g] = fn_tbl[g][vec[g]];
    end

    // Model of the sweep currently being tracked.
    int          m_d, m_S, m_D, m_stop, m_abort, m_cnt, m_ffi;
    logic [15:0] m_cap;
    bit          m_ffv, m_pass;
    bit          trk_on = 1'b0;
    int          cyc = 0;
    int          done_cyc = -1;
    int          ev_vec;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s cycle %0d: got %0h required %0h", nm, cyc, act, req);
        end
    endtask

    // Outcome of a sweep from the truth tables alone.
    task automatic model(input int d, input logic [15:0] f, input logic [15:0] e);
        logic [15:0] diff;
        diff   = f ^ e;
        m_d    = d;
        m_S    = (d == 0) ? 4 : 1;
        m_cnt  = 0;
        m_ffv  = 1'b0;
        m_ffi  = 0;
        m_stop = 15;
        m_cap  = '0;
        for (int i = 0; i < 16; i++) begin
            if (i <= m_stop) begin
                m_cap[i] = f[i];
                if (diff[i]) begin
                    m_cnt++;
                    if (!m_ffv) begin
                        m_ffv = 1'b1;
                        m_ffi = i;
                        if (HALT) m_stop = i;
                    end
                end
            end
        end
        m_pass = (m_cnt == 0);
        m_D    = (m_stop + 1) * (m_S + 1) + 1;
    endtask

    task automatic res_chk(input string tag);
        chk({tag, "_pass"}, pass[m_d], m_pass);
        chk({tag, "_mcnt"}, mcnt[m_d], m_cnt);
        chk({tag, "_captured"}, cap[m_d], m_cap);
        chk({tag, "_ffv"}, ffv[m_d], m_ffv);
        chk({tag, "_ffi"}, ffi[m_d], m_ffi);
    endtask

    // Per-cycle compare against the model while a sweep is tracked.
    always @(negedge clk) begin
        if (trk_on) begin
            ev_vec = (cyc - 1) / (m_S + 1);
            if (ev_vec > m_stop) ev_vec = m_stop;
            if (cyc == 0) begin
                chk("busy_before_start", busy[m_d], 1'b0);
            end else if (m_abort >= 0 && cyc == m_abort + 1) begin
                chk("rst_vec", vec[m_d], 0);
                chk("rst_busy", busy[m_d], 0);
                chk("rst_done", done[m_d], 0);
                chk("rst_pass", pass[m_d], 0);
                chk("rst_mcnt", mcnt[m_d], 0);
                chk("rst_captured", cap[m_d], 0);
                chk("rst_ffi", ffi[m_d], 0);
                chk("rst_ffv", ffv[m_d], 0);
                trk_on = 1'b0;
            end else if (cyc <= m_D) begin
                chk("busy", busy[m_d], 1'b1);
                chk("vec", vec[m_d], ev_vec);
                chk("done", done[m_d], cyc == m_D);
                if (done[m_d] && done_cyc < 0) done_cyc = cyc;
                if (cyc == m_D) res_chk("at_done");
            end else begin
                chk("busy_after", busy[m_d], 1'b0);
                chk("done_after", done[m_d], 1'b0);
                chk("vec_hold", vec[m_d], m_stop);
                res_chk("hold");
                trk_on = 1'b0;
            end
            cyc++;
        end
    end

    task automatic sweep(input int d, input logic [15:0] f, input logic [15:0] e,
                         input int p1, input int p2, input int abort_at);
        @(posedge clk); #2;
        fn_tbl[d]  = f;
        exp_tbl[d] = e;
        model(d, f, e);
        m_abort  = abort_at;
        done_cyc = -1;
        cyc      = 0;
        trk_on   = 1'b1;
        start[d] = 1'b1;
        for (int t = 0; t < 400 && trk_on; t++) begin
            @(posedge clk); #2;
            start[d] = 1'b0;
            if (cyc < m_D && (cyc == p1 || cyc == p2)) start[d] = 1'b1;
            if (cyc == m_D) start[d] = 1'b1;
            if (cyc >= 1 && cyc <= m_D) exp_tbl[d] = 16'($urandom);
            if (cyc == abort_at) rst_n = 1'b0;
        end
        start[d] = 1'b0;
        rst_n    = 1'b1;
        if (trk_on) begin
            chk("sweep_timeout", trk_on, 1'b0);
            trk_on = 1'b0;
        end
    endtask

    initial begin
        logic [15:0] f;
        logic [15:0] e;
        int          d;
        rst_n = 1'b0;
        for (int i = 0; i < 2; i++) begin
            start[i]   = 1'b0;
            exp_tbl[i] = 16'hFFFF;
            fn_tbl[i]  = 16'hFFFF;
        end
        repeat (3) @(posedge clk);
        @(negedge clk);
        for (int i = 0; i < 2; i++) begin
            chk("reset_vec", vec[i], 0);
            chk("reset_busy", busy[i], 0);
            chk("reset_done", done[i], 0);
            chk("reset_pass", pass[i], 0);
            chk("reset_mcnt", mcnt[i], 0);
            chk("reset_captured", cap[i], 0);
            chk("reset_ffi", ffi[i], 0);
            chk("reset_ffv", ffv[i], 0);
        end
        rst_n = 1'b1;

        // XOR function, matching table, restart attempts mid-sweep.
        sweep(0, 16'h6996, 16'h6996, 10, 40, -1);
        chk("lit_xor_done_cycle", done_cyc, 81);
        chk("lit_xor_mcnt", mcnt[0], 0);
        chk("lit_xor_captured", cap[0], 16'h6996);
        chk("lit_xor_pass", pass[0], 1);

        // Single wrong expectation at vector 0.
        sweep(0, 16'h6996, 16'h6997, -1, -1, -1);
        chk("lit_one_mcnt", mcnt[0], 1);
        chk("lit_one_ffi", ffi[0], 0);
        chk("lit_one_pass", pass[0], 0);

        // Output stuck high against an all-zero table.
        sweep(0, 16'hFFFF, 16'h0000, -1, -1, -1);
`ifdef TT_CHECK_HALT_ON_MISMATCH_EN
        chk("lit_stuck_mcnt", mcnt[0], 1);
        chk("lit_stuck_vec", vec[0], 0);
        chk("lit_stuck_done_cycle", done_cyc, 6);
`else
        chk("lit_stuck_mcnt", mcnt[0], 16);
        chk("lit_stuck_captured", cap[0], 16'hFFFF);
`endif
        chk("lit_stuck_ffi", ffi[0], 0);

        // Reset in the middle of a sweep, then a clean sweep.
        sweep(0, 16'h6996, 16'h6996, -1, -1, 30);
        repeat (6) begin
            @(negedge clk);
            chk("no_done_after_abort", done[0], 1'b0);
        end
        sweep(0, 16'h6996, 16'h6996, -1, -1, -1);
        chk("lit_post_abort_done_cycle", done_cyc, 81);

        // Shortest settle time.
        sweep(1, 16'h6996, 16'h6996, -1, -1, -1);
        chk("lit_s1_done_cycle", done_cyc, 33);

        // Randomized functions and tables on both instances.
        for (int n = 0; n < 10; n++) begin
            d = int'($urandom_range(1, 0));
            f = 16'($urandom);
            case ($urandom_range(2, 0))
                0:       e = f;
                1:       e = f ^ (16'h1 << $urandom_range(15, 0));
                default: e = 16'($urandom);
            endcase
            sweep(d, f, e, int'($urandom_range(30, 2)), int'($urandom_range(60, 2)), -1);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
